// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer. A single 1-bit full adder cell is reused
// once per clock, LSB first, and only completed results reach the sum output.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic carryin,
  output logic sum,
  output logic carryout
);
  assign sum      = a ^ b ^ carryin;
  assign carryout = (a & b) | (carryin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             cell_sum, cell_cout;
  logic             accept, last_bit;

  full_adder u_cell (
    .a        (opa_q[0]),
    .b        (opb_q[0]),
    .carryin  (c_q),
    .sum      (cell_sum),
    .carryout (cell_cout)
  );

  // A new request is taken in IDLE and also in DONE, giving back-to-back operation.
  assign accept   = (state_q != RUN) && start;
  assign last_bit = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

  // NOTE: non-blocking assignments for every register so all state updates
  // see pre-edge values; the datapath is reset too, so no stale operand leaks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      shift_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      shift_q <= shift_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: state_d = start ? RUN : IDLE;
      RUN:        if (last_bit) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    c_d     = c_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    shift_d = shift_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      // Subtract is a + ~b + ~carryin, i.e. a - b - borrow_in.
      opa_d = a;
      opb_d = sub ? ~b : b;
      c_d   = carryin ^ sub;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      shift_d = {cell_sum, shift_q[WIDTH-1:1]};
      c_d     = cell_cout;
      opa_d   = opa_q >> 1;
      opb_d   = opb_q >> 1;
      if (last_bit) begin
        sum_d  = {cell_sum, shift_q[WIDTH-1:1]};
        cout_d = cell_cout;
        ovf_d  = c_q ^ cell_cout;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  assign sum      = sum_q;
  assign carryout = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed vectors, random operations
// against an arithmetic reference model, handshake and mid-operation reset.
`timescale 1ns/1ps

module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carryin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carryout;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .carryin  (carryin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carryout (carryout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed views.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic s, input logic ci,
                                output logic [W-1:0] r, output logic co, output logic ov);
    longint ux, uy, sx, sy, cv, t, st;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    cv = ci ? 64'sd1 : 64'sd0;
    if (s) begin
      t  = ux - uy - cv;
      st = sx - sy - cv;
      co = (t >= 0);
    end else begin
      t  = ux + uy + cv;
      st = sx + sy + cv;
      co = (t >= (64'sd1 <<< W));
    end
    r  = t[W-1:0];
    ov = (st > ((64'sd1 <<< (W - 1)) - 1)) || (st < -(64'sd1 <<< (W - 1)));
  endfunction

  task automatic wait_done(input int budget, output int busy_cnt, output bit ok);
    busy_cnt = 0;
    ok       = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic s, input logic ci);
    logic [W-1:0] er;
    logic         eco, eov;
    model(x, y, s, ci, er, eco, eov);
    check({tag, " sum"}, 32'(sum), 32'(er));
    check({tag, " carryout"}, 32'(carryout), 32'(eco));
    check({tag, " overflow"}, 32'(overflow), 32'(eov));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input logic ci);
    int bc;
    bit ok;
    @(negedge clk);
    a = x; b = y; sub = s; carryin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom); carryin = 1'($urandom);
    wait_done(W + 4, bc, ok);
    check({tag, " done seen"}, 32'(ok), 32'd1);
    check({tag, " busy cycles"}, 32'(bc), 32'(W));
    check_result(tag, x, y, s, ci);
    @(negedge clk);
    check({tag, " done one cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int      bc, seen;
    bit      ok;
    longint  t0, t1;

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; carryin = 1'b0;
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset sum", 32'(sum), 32'd0);
    check("reset carryout", 32'(carryout), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add basic", 8'h35, 8'h4A, 1'b0, 1'b0);
    run_op("add wrap", 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op("add ovf", 8'h7F, 8'h01, 1'b0, 1'b0);
    run_op("sub borrow", 8'h10, 8'h20, 1'b1, 1'b0);
    run_op("sub noborrow", 8'h20, 8'h10, 1'b1, 1'b1);
    run_op("sub neg ovf", 8'h80, 8'h01, 1'b1, 1'b0);
    run_op("add cin", 8'hFE, 8'h01, 1'b0, 1'b1);

    for (int i = 0; i < 16; i++)
      run_op("random", W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // start pulsed mid-operation with other operands must be ignored
    @(negedge clk);
    a = 8'h35; b = 8'h4A; sub = 1'b0; carryin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hC3; b = 8'h5A; sub = 1'b1; carryin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(W + 4, bc, ok);
    check("midrun done seen", 32'(ok), 32'd1);
    check_result("midrun", 8'h35, 8'h4A, 1'b0, 1'b0);
    @(negedge clk);
    check("midrun no requeue", 32'(busy), 32'd0);

    // start held through RUN and DONE: back-to-back operation
    @(negedge clk);
    a = 8'h7F; b = 8'h01; sub = 1'b0; carryin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h12; b = 8'h34; sub = 1'b0; carryin = 1'b0;
    wait_done(W + 4, bc, ok);
    t0 = longint'($time);
    check("b2b first done", 32'(ok), 32'd1);
    check_result("b2b first", 8'h7F, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("b2b no idle gap", 32'(busy), 32'd1);
    wait_done(W + 4, bc, ok);
    t1 = longint'($time);
    check("b2b second done", 32'(ok), 32'd1);
    check("b2b done spacing", 32'((t1 - t0) / 10), 32'(W + 1));
    check_result("b2b second", 8'h12, 8'h34, 1'b0, 1'b0);

    // asynchronous reset while bit 4 is being processed
    @(negedge clk);
    a = 8'h55; b = 8'h11; sub = 1'b0; carryin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre-reset busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset sum", 32'(sum), 32'd0);
    check("midreset carryout", 32'(carryout), 32'd0);
    check("midreset overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 2 * W; i++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    check("no done after reset", 32'(seen), 32'd0);

    run_op("after reset", 8'hA5, 8'h5A, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
